// File: rtl/arb_report_tx_pkg.sv
// Shared definitions for the arbitrage engine serial link (transmit and receive paths).
package arb_report_tx_pkg;

   localparam int DEF_CLK_FREQ = 50_000_000;
   localparam int DEF_BAUD     = 9600;

   // Packet framing bytes.
   localparam logic [7:0] HEADER = 8'hAA;
   localparam logic [7:0] FOOTER = 8'h55;

   // Trade action encodings (3 is reserved and passed through untouched).
   localparam logic [1:0] ACT_NONE  = 2'd0;
   localparam logic [1:0] ACT_BUY_A = 2'd1;
   localparam logic [1:0] ACT_BUY_B = 2'd2;

   // Clock cycles per serial bit; integer divide, remainder discarded.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // Which packet byte is currently on the wire.
   typedef enum logic [2:0] {
      F_IDLE,
      F_HDR,
      F_ACT,
      F_PHI,
      F_PLO,
      F_FTR
   } frame_state_t;

   // Position inside one 8N1 character.
   typedef enum logic [1:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_STOP
   } bit_state_t;

endpackage

// File: rtl/arb_report_tx_uart_tx_byte.sv
// 8N1 byte serializer. A start pulse while idle, or on the last clock of a stop
// bit, loads data_in and begins a new character with no idle gap. done flags
// that last stop-bit clock so the caller can chain the next byte.
module uart_tx_byte
   import arb_report_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       done
);

   localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   bit_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [7:0]       byte_q;
   logic             last_clk;
   logic             load;

   assign last_clk = (cnt == LAST);
   assign done     = (state == B_STOP) && last_clk;
   assign load     = start && ((state == B_IDLE) || done);

   // Capture the byte being framed; pure data, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         byte_q <= data_in;
      end
   end

   // Bit FSM with baud counter; tx is driven straight from this flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= B_IDLE;
         cnt   <= '0;
         idx   <= '0;
         tx    <= 1'b1;
      end else begin
         case (state)
            B_IDLE: begin
               if (start) begin
                  state <= B_START;
                  cnt   <= '0;
                  tx    <= 1'b0;
               end
            end
            B_START: begin
               if (last_clk) begin
                  state <= B_DATA;
                  cnt   <= '0;
                  idx   <= '0;
                  tx    <= byte_q[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            B_DATA: begin
               if (last_clk) begin
                  cnt <= '0;
                  if (idx == 3'd7) begin
                     state <= B_STOP;
                     tx    <= 1'b1;
                  end else begin
                     idx <= idx + 3'd1;
                     tx  <= byte_q[idx + 3'd1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            B_STOP: begin
               if (last_clk) begin
                  cnt <= '0;
                  if (start) begin
                     state <= B_START;
                     tx    <= 1'b0;
                  end else begin
                     state <= B_IDLE;
                     tx    <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= B_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/arb_report_tx.sv
// Trade report transmitter: accepts one report, then sends the 5-byte packet
// HEADER, action, profit[15:8], profit[7:0], FOOTER as back-to-back 8N1 bytes.
module arb_report_tx
   import arb_report_tx_pkg::*;
#(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int BAUD     = DEF_BAUD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        report_valid,
   output logic        report_ready,
   input  logic [1:0]  action,
   input  logic [15:0] profit,
   output logic        uart_tx,
   output logic        busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

   frame_state_t fstate;
   logic [1:0]   action_q;
   logic [15:0]  profit_q;
   logic         accept;
   logic         byte_start;
   logic         byte_done;
   logic [7:0]   byte_data;

   // report_ready is only high in F_IDLE, so this also gates out reports while busy.
   assign accept = report_valid && report_ready;

   // Latch the report on the accept edge; later input changes do not matter.
   always_ff @(posedge clk) begin
      if (accept) begin
         action_q <= action;
         profit_q <= profit;
      end
   end

   // Choose the next byte and when to hand it over: the header goes out on the
   // accept edge itself, every later byte on the final clock of the previous stop bit.
   always_comb begin
      byte_start = 1'b0;
      byte_data  = HEADER;
      case (fstate)
         F_IDLE: begin
            byte_start = accept;
            byte_data  = HEADER;
         end
         F_HDR: begin
            byte_start = byte_done;
            byte_data  = {6'b0, action_q};
         end
         F_ACT: begin
            byte_start = byte_done;
            byte_data  = profit_q[15:8];
         end
         F_PHI: begin
            byte_start = byte_done;
            byte_data  = profit_q[7:0];
         end
         F_PLO: begin
            byte_start = byte_done;
            byte_data  = FOOTER;
         end
         default: begin
            byte_start = 1'b0;
            byte_data  = FOOTER;
         end
      endcase
   end

   // Frame sequencer with registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fstate       <= F_IDLE;
         busy         <= 1'b0;
         report_ready <= 1'b1;
      end else begin
         case (fstate)
            F_IDLE: begin
               if (accept) begin
                  fstate       <= F_HDR;
                  busy         <= 1'b1;
                  report_ready <= 1'b0;
               end
            end
            F_HDR: if (byte_done) fstate <= F_ACT;
            F_ACT: if (byte_done) fstate <= F_PHI;
            F_PHI: if (byte_done) fstate <= F_PLO;
            F_PLO: if (byte_done) fstate <= F_FTR;
            F_FTR: begin
               if (byte_done) begin
                  fstate       <= F_IDLE;
                  busy         <= 1'b0;
                  report_ready <= 1'b1;
               end
            end
            default: begin
               fstate       <= F_IDLE;
               busy         <= 1'b0;
               report_ready <= 1'b1;
            end
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk     (clk),
      .rst     (rst),
      .start   (byte_start),
      .data_in (byte_data),
      .tx      (uart_tx),
      .done    (byte_done)
   );

endmodule

// File: tb/tb_arb_report_tx.sv
// Bench for arb_report_tx at a reduced bit rate (16 clocks per bit).
module tb_arb_report_tx;

   localparam int CLK_FREQ = 160;
   localparam int BAUD     = 10;
   localparam int CPB      = 16;
   localparam int PKT      = 50 * CPB;

   logic        clk = 1'b0;
   logic        rst;
   logic        report_valid;
   logic        report_ready;
   logic [1:0]  action;
   logic [15:0] profit;
   logic        uart_tx;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] exp_q[$];
   int         starts[$];

   typedef struct {
      logic [1:0]  act;
      logic [15:0] prof;
      bit          hold;
      bit          change;
   } vec_t;

   vec_t vecs[5];

   arb_report_tx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .report_valid (report_valid),
      .report_ready (report_ready),
      .action       (action),
      .profit       (profit),
      .uart_tx      (uart_tx),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_pkt(input logic [1:0] a, input logic [15:0] p);
      exp_q.push_back(8'hAA);
      exp_q.push_back({6'b0, a});
      exp_q.push_back(p[15:8]);
      exp_q.push_back(p[7:0]);
      exp_q.push_back(8'h55);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (report_ready !== 1'b1 && n < 2 * PKT) begin
         @(negedge clk);
         n++;
      end
      if (report_ready !== 1'b1) chk(1'b0, "ready_timeout", n, 2 * PKT);
   endtask

   // Present one report, wait for its packet to finish, check handshake and length.
   task automatic send_report(input logic [1:0] a, input logic [15:0] p, input bit hold, input bit change);
      int n;
      wait_ready();
      action       = a;
      profit       = p;
      report_valid = 1'b1;
      push_pkt(a, p);
      @(posedge clk);
      #1;
      if (!hold) report_valid = 1'b0;
      if (change) begin
         action = 2'd0;
         profit = 16'd0;
      end
      chk(busy === 1'b1 && report_ready === 1'b0, "accept_handshake", int'(busy), 1);
      @(negedge clk);
      chk(uart_tx === 1'b0, "header_start_latency", int'(uart_tx), 0);
      n = 1;
      while (busy === 1'b1 && n < 2 * PKT) begin
         @(negedge clk);
         if (busy === 1'b1) n++;
      end
      report_valid = 1'b0;
      chk(n == PKT, "packet_length", n, PKT);
      chk(report_ready === 1'b1, "ready_after_packet", int'(report_ready), 1);
      repeat (2) @(negedge clk);
      chk(exp_q.size() == 0, "all_bytes_seen", exp_q.size(), 0);
   endtask

   // Receiver model: decode 8N1 characters, checking every bit is flat for CPB clocks.
   initial begin : monitor
      logic [7:0] d;
      logic [7:0] e;
      logic       v;
      bit         ok;
      bit         ab;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && uart_tx === 1'b0) begin
            starts.push_back(cyc);
            ok = 1'b1;
            ab = 1'b0;
            d  = '0;
            v  = 1'b0;
            for (int k = 0; k < 10; k++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (!ab) begin
                     if (k != 0 || c != 0) @(negedge clk);
                     if (rst !== 1'b0) begin
                        ab = 1'b1;
                     end else if (c == 0) begin
                        v = uart_tx;
                        if (k == 0 && v !== 1'b0) ok = 1'b0;
                        if (k == 9 && v !== 1'b1) ok = 1'b0;
                        if (k >= 1 && k <= 8) d[k-1] = v;
                     end else if (uart_tx !== v) begin
                        ok = 1'b0;
                     end
                  end
               end
            end
            if (!ab) begin
               chk(ok, "byte_framing", int'(ok), 1);
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_byte", int'(d), -1);
               end else begin
                  e = exp_q.pop_front();
                  chk(d === e, "byte_value", int'(d), int'(e));
               end
            end
         end
      end
   end

   initial begin : main
      bit idle_ok;
      int n;
      vecs[0] = '{act: 2'd2, prof: 16'd35,    hold: 1'b0, change: 1'b0};
      vecs[1] = '{act: 2'd1, prof: 16'hABCD, hold: 1'b1, change: 1'b0};
      vecs[2] = '{act: 2'd3, prof: 16'hFFFF, hold: 1'b0, change: 1'b1};
      vecs[3] = '{act: 2'd0, prof: 16'h0000, hold: 1'b0, change: 1'b0};
      vecs[4] = '{act: 2'd2, prof: 16'h8001, hold: 1'b0, change: 1'b1};

      rst          = 1'b1;
      report_valid = 1'b0;
      action       = 2'd0;
      profit       = 16'd0;
      repeat (3) @(negedge clk);
      chk(uart_tx === 1'b1, "reset_tx", int'(uart_tx), 1);
      chk(busy === 1'b0, "reset_busy", int'(busy), 0);
      rst = 1'b0;
      @(negedge clk);
      chk(report_ready === 1'b1, "reset_ready", int'(report_ready), 1);

      // Idle line with no report.
      idle_ok = 1'b1;
      repeat (1000) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || report_ready !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
      end
      chk(idle_ok, "idle_1000", int'(idle_ok), 1);

      // Table of reports.
      for (int i = 0; i < 5; i++) begin
         send_report(vecs[i].act, vecs[i].prof, vecs[i].hold, vecs[i].change);
      end

      // Reset during the profit-high data bits aborts the packet.
      wait_ready();
      action       = 2'd2;
      profit       = 16'h1234;
      report_valid = 1'b1;
      push_pkt(2'd2, 16'h1234);
      @(posedge clk);
      #1;
      report_valid = 1'b0;
      repeat (24 * CPB + 1 + CPB / 2) @(negedge clk);
      chk(uart_tx === 1'b0, "phi_bit3_low", int'(uart_tx), 0);
      rst = 1'b1;
      #1;
      chk(uart_tx === 1'b1, "abort_tx_same_cycle", int'(uart_tx), 1);
      chk(busy === 1'b0, "abort_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk(exp_q.size() == 3, "bytes_before_abort", 5 - exp_q.size(), 2);
      exp_q.delete();
      idle_ok = 1'b1;
      repeat (200) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || report_ready !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
      end
      chk(idle_ok, "quiet_after_abort", int'(idle_ok), 1);
      send_report(2'd1, 16'h5AA5, 1'b0, 1'b0);

      // Two reports back to back.
      wait_ready();
      starts.delete();
      action       = 2'd2;
      profit       = 16'h0102;
      report_valid = 1'b1;
      push_pkt(2'd2, 16'h0102);
      push_pkt(2'd1, 16'hFEDC);
      @(posedge clk);
      #1;
      action = 2'd1;
      profit = 16'hFEDC;
      n = 0;
      @(negedge clk);
      while (report_ready !== 1'b1 && n < 2 * PKT) begin
         @(negedge clk);
         n++;
      end
      chk(report_ready === 1'b1, "b2b_ready_first", int'(report_ready), 1);
      @(posedge clk);
      #1;
      chk(busy === 1'b1 && report_ready === 1'b0, "b2b_second_accept", int'(busy), 1);
      report_valid = 1'b0;
      wait_ready();
      repeat (2) @(negedge clk);
      chk(exp_q.size() == 0, "b2b_all_bytes", exp_q.size(), 0);
      chk(starts.size() == 10, "b2b_byte_count", starts.size(), 10);
      if (starts.size() == 10) begin
         for (int i = 1; i < 10; i++) begin
            chk(starts[i] - starts[i-1] == ((i == 5) ? 10 * CPB + 1 : 10 * CPB),
                "b2b_byte_spacing", starts[i] - starts[i-1], (i == 5) ? 10 * CPB + 1 : 10 * CPB);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
